// File: rtl/manchester_tx.sv
// manchester_tx -- framed Manchester serializer fed by an AXI-Stream payload port.
// Frame on the line: preamble (1,0,1,0,...), 8-bit SFD, payload words MSB first,
// optional CRC-8, then a silent inter-frame gap.
// Bit 1 is sent as half-bits 0 then 1, bit 0 as half-bits 1 then 0.
// Optional feature: define MANCHESTER_TX_CRC_EN to append a CRC-8
// (poly 0x07, init 0x00, over payload bits in transmit order) after the payload.
module manchester_tx #(
    parameter int         DATA_WIDTH      = 8,
    parameter int         HALF_BIT_CYCLES = 1,
    parameter int         PREAMBLE_BITS   = 32,
    parameter logic [7:0] SFD             = 8'hD5,
    parameter int         IFG_BITS        = 12
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  serial_out,
    output logic                  serial_oe,
    output logic                  busy,
    output logic                  underrun
);

    // Terminal counts. Every counter is 8 bits wide, which covers the largest
    // legal value of each parameter (255), so no field can wrap a counter.
    localparam logic [7:0] HB_LAST   = 8'(HALF_BIT_CYCLES - 1);
    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_BITS - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_WIDTH - 1);
    localparam logic [7:0] IFG_LAST  = 8'(IFG_BITS - 1);
    localparam logic [7:0] BYTE_LAST = 8'd7;
    localparam logic [7:0] SFD_BITS  = SFD;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
`ifdef MANCHESTER_TX_CRC_EN
        ST_CRC      = 3'd4,
`endif
        ST_GAP      = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                state_q, state_d;
    logic [7:0]            cyc_q, cyc_d;       // cycle inside the current half-bit
    logic                  half_q, half_d;     // 0 = first half, 1 = second half
    logic [7:0]            bit_q, bit_d;       // bit index inside the current field
    logic [DATA_WIDTH-1:0] shift_q, shift_d;   // payload word, MSB is the bit on the line
    logic                  last_q, last_d;     // word in shift_q carried tlast
`ifdef MANCHESTER_TX_CRC_EN
    logic [7:0]            crc_q, crc_d;       // running CRC, then shifted out MSB first
    logic                  crc_fb;
`endif
    logic                  serial_q, serial_d;
    logic                  oe_q, oe_d;
    logic                  underrun_q, underrun_d;

    // ------------------------------------------------------------------
    // Timing decodes derived from the counters
    // ------------------------------------------------------------------
    logic half_end;     // last cycle of a half-bit
    logic bit_end;      // last cycle of a bit
    logic field_last;   // current bit is the last bit of the field
    logic field_end;    // last cycle of the field
    logic tready_int;
    logic accept;       // handshake this cycle
    logic abort;        // payload ran dry mid-frame
    logic line_bit;     // bit value that the next cycle puts on the line
    logic active_d;     // next cycle drives the line

    assign half_end = (cyc_q == HB_LAST);
    assign bit_end  = half_end & half_q;

    // Length of the field currently being sent
    always_comb begin
        field_last = 1'b0;
        case (state_q)
            ST_PREAMBLE: field_last = (bit_q == PRE_LAST);
            ST_SFD:      field_last = (bit_q == BYTE_LAST);
            ST_DATA:     field_last = (bit_q == DATA_LAST);
`ifdef MANCHESTER_TX_CRC_EN
            ST_CRC:      field_last = (bit_q == BYTE_LAST);
`endif
            ST_GAP:      field_last = (bit_q == IFG_LAST);
            default:     field_last = 1'b0;
        endcase
    end

    assign field_end = bit_end & field_last;

    // A word is requested on the final cycle of the SFD and on the final cycle
    // of every payload word that is not the end of the frame. The word that
    // launched the frame therefore waits on the port until the SFD is done.
    assign tready_int = field_end &
                        ((state_q == ST_SFD) | ((state_q == ST_DATA) & ~last_q));
    assign accept     = tready_int & s_axis_tvalid;
    assign abort      = tready_int & ~s_axis_tvalid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Holds the frame phase; reset truncates any frame straight to IDLE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // Phase sequencing; every transition out of a field happens on field_end.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid) begin
                    state_d = ST_PREAMBLE;
                end
            end
            ST_PREAMBLE: begin
                if (field_end) begin
                    state_d = ST_SFD;
                end
            end
            ST_SFD: begin
                if (field_end) begin
                    state_d = s_axis_tvalid ? ST_DATA : ST_GAP;
                end
            end
            ST_DATA: begin
                if (field_end) begin
                    if (last_q) begin
`ifdef MANCHESTER_TX_CRC_EN
                        state_d = ST_CRC;
`else
                        state_d = ST_GAP;
`endif
                    end else begin
                        // Back-to-back word, or abort when the source is empty.
                        state_d = s_axis_tvalid ? ST_DATA : ST_GAP;
                    end
                end
            end
`ifdef MANCHESTER_TX_CRC_EN
            ST_CRC: begin
                if (field_end) begin
                    state_d = ST_GAP;
                end
            end
`endif
            ST_GAP: begin
                if (field_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Half-bit / bit counters
    // ------------------------------------------------------------------
    // Counters run in every non-idle state and return to zero at each field end,
    // so every field begins at cycle 0, first half, bit 0.
    always_comb begin
        cyc_d  = cyc_q;
        half_d = half_q;
        bit_d  = bit_q;
        if (state_q == ST_IDLE) begin
            cyc_d  = 8'd0;
            half_d = 1'b0;
            bit_d  = 8'd0;
        end else if (half_end) begin
            cyc_d  = 8'd0;
            half_d = ~half_q;
            if (half_q) begin
                bit_d = field_last ? 8'd0 : bit_q + 8'd1;
            end
        end else begin
            cyc_d = cyc_q + 8'd1;
        end
    end

    // Counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cyc_q  <= 8'd0;
            half_q <= 1'b0;
            bit_q  <= 8'd0;
        end else begin
            cyc_q  <= cyc_d;
            half_q <= half_d;
            bit_q  <= bit_d;
        end
    end

    // ------------------------------------------------------------------
    // Payload shift register
    // ------------------------------------------------------------------
    // Loads on a handshake, otherwise shifts left once per payload bit.
    always_comb begin
        shift_d = shift_q;
        last_d  = last_q;
        if (accept) begin
            shift_d = s_axis_tdata;
            last_d  = s_axis_tlast;
        end else if ((state_q == ST_DATA) && bit_end) begin
            shift_d = shift_q << 1;
        end
    end

    // Shift register and tlast flag
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            shift_q <= '0;
            last_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            last_q  <= last_d;
        end
    end

`ifdef MANCHESTER_TX_CRC_EN
    // ------------------------------------------------------------------
    // CRC-8, polynomial x^8 + x^2 + x + 1
    // ------------------------------------------------------------------
    assign crc_fb = crc_q[7] ^ shift_q[DATA_WIDTH-1];

    // Cleared during the SFD, folds in each payload bit as it finishes on the
    // line, then doubles as the output shifter while the CRC field is sent.
    always_comb begin
        crc_d = crc_q;
        if (state_q == ST_SFD) begin
            crc_d = 8'h00;
        end else if ((state_q == ST_DATA) && bit_end) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
        end else if ((state_q == ST_CRC) && bit_end) begin
            crc_d = {crc_q[6:0], 1'b0};
        end
    end

    // CRC register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // The line is registered, so its next value is decoded from the next-state
    // view (state_d and the _d counters); the first preamble half-bit then
    // appears in the cycle right after IDLE sees tvalid.
    always_comb begin
        line_bit = 1'b0;
        active_d = 1'b0;
        case (state_d)
            ST_PREAMBLE: begin
                line_bit = ~bit_d[0];
                active_d = 1'b1;
            end
            ST_SFD: begin
                line_bit = SFD_BITS[3'd7 - bit_d[2:0]];
                active_d = 1'b1;
            end
            ST_DATA: begin
                line_bit = shift_d[DATA_WIDTH-1];
                active_d = 1'b1;
            end
`ifdef MANCHESTER_TX_CRC_EN
            ST_CRC: begin
                line_bit = crc_d[7];
                active_d = 1'b1;
            end
`endif
            default: begin
                line_bit = 1'b0;
                active_d = 1'b0;
            end
        endcase
        serial_d   = active_d & (half_d ? line_bit : ~line_bit);
        oe_d       = active_d;
        underrun_d = abort;
    end

    // Registered line, driver enable and abort pulse
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            serial_q   <= 1'b0;
            oe_q       <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            serial_q   <= serial_d;
            oe_q       <= oe_d;
            underrun_q <= underrun_d;
        end
    end

    assign serial_out    = serial_q;
    assign serial_oe     = oe_q;
    assign underrun      = underrun_q;
    assign busy          = (state_q != ST_IDLE);
    assign s_axis_tready = tready_int;

endmodule

// File: tb/tb_manchester_tx.sv
// Bench for manchester_tx: two instances (1 and 3 cycles per half-bit), a table
// of frames, a per-cycle expected-trace queue built from the line rules, and a
// hand-written mid-frame reset sequence.
`timescale 1ns/1ps
module tb_manchester_tx;

`ifdef MANCHESTER_TX_CRC_EN
    localparam int CRCC = 16;
`else
    localparam int CRCC = 0;
`endif
    localparam int IFG0 = 12;
    localparam int IFG1 = 2;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    logic [1:0][7:0] tdata;
    logic [1:0] tvalid;
    logic [1:0] tlast;
    wire  [1:0] tready;
    wire  [1:0] sout;
    wire  [1:0] soe;
    wire  [1:0] busy;
    wire  [1:0] und;

    always #5 aclk = ~aclk;

    manchester_tx #(
        .DATA_WIDTH(8), .HALF_BIT_CYCLES(1), .PREAMBLE_BITS(8), .SFD(8'hD5), .IFG_BITS(IFG0)
    ) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
        .s_axis_tlast(tlast[0]), .serial_out(sout[0]), .serial_oe(soe[0]),
        .busy(busy[0]), .underrun(und[0])
    );

    manchester_tx #(
        .DATA_WIDTH(8), .HALF_BIT_CYCLES(3), .PREAMBLE_BITS(8), .SFD(8'hD5), .IFG_BITS(IFG1)
    ) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
        .s_axis_tlast(tlast[1]), .serial_out(sout[1]), .serial_oe(soe[1]),
        .busy(busy[1]), .underrun(und[1])
    );

    typedef struct {
        int         sel;       // 0: 1 cycle/half-bit, 1: 3 cycles/half-bit
        int         n;         // words in the frame
        logic [7:0] w [3];
        bit         drop;      // tvalid withdrawn at the second word
        bit         b2b;       // next frame's word already valid during GAP
        int         exp_rdy;   // tready pulses
        int         exp_oe;    // cycles with serial_oe high
        int         exp_und;   // underrun pulses
    } vec_t;

    vec_t tab [8];
    logic [4:0] exp_q [$];     // {serial_out, serial_oe, busy, tready, underrun}
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] obs(input int s);
        return {sout[s], soe[s], busy[s], tready[s], und[s]};
    endfunction

    function automatic void set_vec(input int i, input int sel, input int n,
                                    input logic [7:0] w0, input logic [7:0] w1,
                                    input logic [7:0] w2, input bit drop, input bit b2b,
                                    input int rdy, input int oe, input int un);
        tab[i].sel = sel;  tab[i].n = n;
        tab[i].w[0] = w0;  tab[i].w[1] = w1;  tab[i].w[2] = w2;
        tab[i].drop = drop; tab[i].b2b = b2b;
        tab[i].exp_rdy = rdy; tab[i].exp_oe = oe; tab[i].exp_und = un;
    endfunction

    // One Manchester bit: first half is the complement, second half the bit.
    task automatic push_bit(input int hbc, input logic b, input logic rdy);
        for (int h = 0; h < 2; h++) begin
            for (int c = 0; c < hbc; c++) begin
                exp_q.push_back({((h == 1) ? b : ~b), 1'b1, 1'b1,
                                 (rdy && (h == 1) && (c == hbc - 1)), 1'b0});
            end
        end
    endtask

    // Expected per-cycle trace from the cycle after tvalid is seen in IDLE
    // through the single IDLE cycle that follows the gap.
    task automatic build_frame(input int v);
        int hbc;
        int ifg;
        int nacc;
        logic [7:0] crc;
        logic [7:0] w;
        logic [7:0] sfd;
        logic fb;
        sfd  = 8'hD5;
        hbc  = (tab[v].sel != 0) ? 3 : 1;
        ifg  = (tab[v].sel != 0) ? IFG1 : IFG0;
        for (int i = 0; i < 8; i++) push_bit(hbc, ((i % 2) == 0), 1'b0);
        for (int i = 7; i >= 0; i--) push_bit(hbc, sfd[i], (i == 0));
        nacc = tab[v].drop ? 1 : tab[v].n;
        crc  = 8'h00;
        for (int k = 0; k < nacc; k++) begin
            w = tab[v].w[k];
            for (int i = 7; i >= 0; i--) begin
                push_bit(hbc, w[i], (i == 0) && (tab[v].drop || (k < tab[v].n - 1)));
                fb  = crc[7] ^ w[i];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`ifdef MANCHESTER_TX_CRC_EN
        if (!tab[v].drop) begin
            for (int i = 7; i >= 0; i--) push_bit(hbc, crc[i], 1'b0);
        end
`endif
        for (int g = 0; g < ifg * 2 * hbc; g++) begin
            exp_q.push_back({4'b0010, (tab[v].drop && (g == 0))});
        end
        exp_q.push_back(5'b00000);
    endtask

    task automatic drive_word(input int v, input int k);
        int s;
        s = tab[v].sel;
        tdata[s]  = tab[v].w[k];
        tlast[s]  = (k == tab[v].n - 1) && !tab[v].drop;
        tvalid[s] = 1'b1;
    endtask

    // Called at a falling edge while the DUT is idle; returns at the falling
    // edge of the IDLE cycle that follows the gap.
    task automatic run_frame(input int v);
        int s;
        int idx;
        int cyc;
        int rdy_cnt;
        int oe_cnt;
        int und_cnt;
        logic hs;
        logic [4:0] e;
        s = tab[v].sel;
        build_frame(v);
        idx = 0; cyc = 0; rdy_cnt = 0; oe_cnt = 0; und_cnt = 0; hs = 1'b0;
        drive_word(v, 0);
        while (exp_q.size() != 0) begin
            @(posedge aclk);
            #1;
            if (hs) begin
                idx++;
                if (idx < tab[v].n && !(tab[v].drop && idx == 1)) drive_word(v, idx);
                else if (tab[v].b2b) drive_word(v + 1, 0);
                else tvalid[s] = 1'b0;
            end
            @(negedge aclk);
            e = exp_q.pop_front();
            check($sformatf("v%0d cyc%0d line/oe/busy/rdy/und", v, cyc), 32'(obs(s)), 32'(e));
            rdy_cnt += int'(tready[s]);
            oe_cnt  += int'(soe[s]);
            und_cnt += int'(und[s]);
            hs = tready[s] & tvalid[s];
            cyc++;
        end
        check($sformatf("v%0d tready pulses", v), 32'(rdy_cnt), 32'(tab[v].exp_rdy));
        check($sformatf("v%0d serial_oe cycles", v), 32'(oe_cnt), 32'(tab[v].exp_oe));
        check($sformatf("v%0d underrun pulses", v), 32'(und_cnt), 32'(tab[v].exp_und));
        $display("frame v%0d done: %0d cycles, tready=%0d oe=%0d underrun=%0d",
                 v, cyc, rdy_cnt, oe_cnt, und_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        //        idx sel n  w0     w1     w2     drop b2b rdy oe                und
        set_vec(0, 0, 1, 8'hA5, 8'h00, 8'h00, 0, 0, 1, 48 + CRCC,         0);
        set_vec(1, 0, 3, 8'h01, 8'h02, 8'h03, 0, 0, 3, 80 + CRCC,         0);
        set_vec(2, 0, 2, 8'h5A, 8'h77, 8'h00, 1, 0, 2, 48,                1);
        set_vec(3, 1, 2, 8'h00, 8'hFF, 8'h00, 0, 0, 2, 192 + 3 * CRCC,    0);
        set_vec(4, 0, 1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 48 + CRCC,         0);
        set_vec(5, 0, 2, 8'hC3, 8'h3C, 8'h00, 0, 0, 2, 64 + CRCC,         0);
        set_vec(6, 1, 3, 8'h81, 8'h42, 8'h24, 1, 0, 2, 144,               1);
        set_vec(7, 0, 1, 8'h3C, 8'h00, 8'h00, 0, 0, 1, 48 + CRCC,         0);

        tvalid = '0;
        tlast  = '0;
        tdata  = '0;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        check("reset dut0 outputs", 32'(obs(0)), 32'd0);
        check("reset dut1 outputs", 32'(obs(1)), 32'd0);
        aresetn = 1'b1;

        for (int v = 0; v < 7; v++) run_frame(v);

        // Reset asserted in the middle of the payload of a frame on dut0.
        tdata[0]  = 8'h96;
        tlast[0]  = 1'b1;
        tvalid[0] = 1'b1;
        repeat (38) @(negedge aclk);
        tvalid[0] = 1'b0;
        check("pre-reset busy/oe", 32'({busy[0], soe[0]}), 32'd3);
        aresetn = 1'b0;
        #1;
        check("reset mid-frame outputs", 32'(obs(0)), 32'd0);
        @(negedge aclk);
        check("reset held outputs", 32'(obs(0)), 32'd0);
        aresetn = 1'b1;
        run_frame(7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
